fuser_sequencer: RTL and testbench

Collects one hypervector from each of the three sensor modalities, which may arrive on different cycles. Majority-fuses them through an internal `fuser` and holds the registered result on a valid/ready output toward the associative-memory stage. Sits between the three per-modality encoders and the classifier. A partial set that does not complete within a programmable number of cycles is discarded and counted as a drop.

---
 rtl/fuser_sequencer_pkg.sv | 20 ++
 rtl/fuser_sequencer_fuser.sv | 22 ++
 rtl/fuser_sequencer.sv | 144 ++++++++++++++
 tb/tb_fuser_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuser_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the fuser sequencer.
package fuser_sequencer_pkg;

    localparam int unsigned HV_DIMENSION = 1024;

    typedef enum logic [1:0] {
        FSEQ_IDLE    = 2'd0,
        FSEQ_COLLECT = 2'd1,
        FSEQ_EMIT    = 2'd2
    } fseq_state_e;

    // Smallest n with 2**n >= value.
    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned n;
        n = 0;
        while ((64'd1 << n) < 64'(value)) n++;
        return n;
    endfunction

endpackage

// File: rtl/fuser_sequencer_fuser.sv
// Bitwise three-input majority fuser; purely combinational, always ready.
module fuser_sequencer_fuser
    import fuser_sequencer_pkg::*;
#(
    parameter int unsigned DIM = HV_DIMENSION
) (
    input  logic [DIM-1:0] hv1,
    input  logic [DIM-1:0] hv2,
    input  logic [DIM-1:0] hv3,
    input  logic           hv1_valid,
    input  logic           hv2_valid,
    input  logic           hv3_valid,
    output logic [DIM-1:0] hv,
    output logic           hv_valid,
    output logic           ready
);

    assign hv       = (hv1 & hv2) | (hv1 & hv3) | (hv2 & hv3);
    assign hv_valid = hv1_valid & hv2_valid & hv3_valid;
    assign ready    = 1'b1;

endmodule

// File: rtl/fuser_sequencer.sv
// Gathers one hypervector per modality, majority-fuses the set and holds it on a
// valid/ready output; partial sets that wait too long are dropped and counted.
module fuser_sequencer
    import fuser_sequencer_pkg::*;
#(
    parameter int unsigned DIM     = HV_DIMENSION,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned DROP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hvin1_valid,
    input  logic              hvin2_valid,
    input  logic              hvin3_valid,
    output logic              hvin1_ready,
    output logic              hvin2_ready,
    output logic              hvin3_ready,
    input  logic [DIM-1:0]    hvin1,
    input  logic [DIM-1:0]    hvin2,
    input  logic [DIM-1:0]    hvin3,
    output logic              hvout_valid,
    input  logic              hvout_ready,
    output logic [DIM-1:0]    hvout,
    output logic              timeout,
    output logic [DROP_W-1:0] drop_count
);

    localparam int unsigned WCNT_W = (TIMEOUT == 0) ? 1 : ceil_log2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = (TIMEOUT == 0) ? '0 : WCNT_W'(TIMEOUT - 1);

    fseq_state_e       state;
    logic [2:0]        cap;
    logic [2:0]        in_valid;
    logic [2:0]        in_ready;
    logic [2:0]        accept;
    logic [DIM-1:0]    in_hv  [3];
    logic [DIM-1:0]    slot   [3];
    logic [DIM-1:0]    mux_hv [3];
    logic [DIM-1:0]    fused;
    logic [WCNT_W-1:0] wcnt;
    logic              complete;
    logic              expire;
    logic              fuse_valid_unused;
    logic              fuse_ready_unused;

    assign in_valid = {hvin3_valid, hvin2_valid, hvin1_valid};
    assign in_hv[0] = hvin1;
    assign in_hv[1] = hvin2;
    assign in_hv[2] = hvin3;

    // Readies depend only on registered state, never on hvout_ready.
    assign in_ready = (state == FSEQ_EMIT) ? 3'b000 : ~cap;
    assign accept   = in_valid & in_ready;

    assign hvin1_ready = in_ready[0];
    assign hvin2_ready = in_ready[1];
    assign hvin3_ready = in_ready[2];

    assign complete = (state != FSEQ_EMIT) && ((cap | accept) == 3'b111);
    // Completion in the final waiting cycle takes priority over the drop.
    assign expire   = (TIMEOUT != 0) && (state == FSEQ_COLLECT) && (wcnt == WCNT_LAST)
                      && !complete;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mux_hv[k] = accept[k] ? in_hv[k] : slot[k];
        end
    end

    fuser_sequencer_fuser #(
        .DIM (DIM)
    ) u_fuser (
        .hv1       (mux_hv[0]),
        .hv2       (mux_hv[1]),
        .hv3       (mux_hv[2]),
        .hv1_valid (1'b1),
        .hv2_valid (1'b1),
        .hv3_valid (1'b1),
        .hv        (fused),
        .hv_valid  (fuse_valid_unused),
        .ready     (fuse_ready_unused)
    );

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (accept[k]) slot[k] <= in_hv[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FSEQ_IDLE;
            cap         <= 3'b000;
            wcnt        <= '0;
            hvout       <= '0;
            hvout_valid <= 1'b0;
            timeout     <= 1'b0;
            drop_count  <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                FSEQ_IDLE: begin
                    if (complete) begin
                        hvout       <= fused;
                        hvout_valid <= 1'b1;
                        cap         <= 3'b000;
                        state       <= FSEQ_EMIT;
                    end else if (|accept) begin
                        cap   <= accept;
                        wcnt  <= '0;
                        state <= FSEQ_COLLECT;
                    end
                end
                FSEQ_COLLECT: begin
                    if (complete) begin
                        hvout       <= fused;
                        hvout_valid <= 1'b1;
                        cap         <= 3'b000;
                        state       <= FSEQ_EMIT;
                    end else if (expire) begin
                        cap     <= 3'b000;
                        timeout <= 1'b1;
                        state   <= FSEQ_IDLE;
                        if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + 1'b1;
                    end else begin
                        cap  <= cap | accept;
                        wcnt <= wcnt + 1'b1;
                    end
                end
                FSEQ_EMIT: begin
                    if (hvout_ready) begin
                        hvout_valid <= 1'b0;
                        state       <= FSEQ_IDLE;
                    end
                end
                default: begin
                    cap   <= 3'b000;
                    state <= FSEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fuser_sequencer.sv
// Self-checking bench: directed table, corner-case sequences and random traffic
// against a set-level reference model; a second instance exercises counter saturation.
module tb_fuser_sequencer;

    localparam int unsigned DIM     = 16;
    localparam int unsigned TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     vin;
    logic [DIM-1:0] hin [3];
    logic           hvout_ready;

    logic           hvin1_ready, hvin2_ready, hvin3_ready;
    logic           hvout_valid, timeout;
    logic [DIM-1:0] hvout;
    logic [15:0]    drop_count;

    logic           s_rdy1, s_rdy2, s_rdy3, s_valid, s_to;
    logic [DIM-1:0] s_out;
    logic [1:0]     s_drops;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the set currently holds, in plain terms.
    bit             m_held [3];
    logic [DIM-1:0] m_val  [3];
    int             m_waited;
    bit             m_emit;
    logic [DIM-1:0] m_out;
    bit             m_to;
    int             m_drops;

    typedef struct packed {
        logic [2:0]     v;
        logic [DIM-1:0] h1;
        logic [DIM-1:0] h2;
        logic [DIM-1:0] h3;
        logic           rdy;
        logic           e_valid;
        logic [DIM-1:0] e_out;
        logic [2:0]     e_ready;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    fuser_sequencer #(.DIM(DIM), .TIMEOUT(TIMEOUT), .DROP_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .hvin1_valid (vin[0]),
        .hvin2_valid (vin[1]),
        .hvin3_valid (vin[2]),
        .hvin1_ready (hvin1_ready),
        .hvin2_ready (hvin2_ready),
        .hvin3_ready (hvin3_ready),
        .hvin1       (hin[0]),
        .hvin2       (hin[1]),
        .hvin3       (hin[2]),
        .hvout_valid (hvout_valid),
        .hvout_ready (hvout_ready),
        .hvout       (hvout),
        .timeout     (timeout),
        .drop_count  (drop_count)
    );

    fuser_sequencer #(.DIM(DIM), .TIMEOUT(TIMEOUT), .DROP_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .hvin1_valid (vin[0]),
        .hvin2_valid (vin[1]),
        .hvin3_valid (vin[2]),
        .hvin1_ready (s_rdy1),
        .hvin2_ready (s_rdy2),
        .hvin3_ready (s_rdy3),
        .hvin1       (hin[0]),
        .hvin2       (hin[1]),
        .hvin3       (hin[2]),
        .hvout_valid (s_valid),
        .hvout_ready (hvout_ready),
        .hvout       (s_out),
        .timeout     (s_to),
        .drop_count  (s_drops)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit got [3];
        bit full, any_held, any_got;
        int ones;
        logic [DIM-1:0] pick [3];
        if (rst) begin
            for (int k = 0; k < 3; k++) m_held[k] = 1'b0;
            m_emit = 1'b0; m_out = '0; m_to = 1'b0; m_drops = 0; m_waited = 0;
            return;
        end
        m_to = 1'b0;
        if (m_emit) begin
            if (hvout_ready) m_emit = 1'b0;
            return;
        end
        full = 1'b1; any_held = 1'b0; any_got = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got[k]  = vin[k] && !m_held[k];
            pick[k] = m_held[k] ? m_val[k] : hin[k];
            full     = full && (m_held[k] || got[k]);
            any_held = any_held || m_held[k];
            any_got  = any_got || got[k];
        end
        if (full) begin
            for (int b = 0; b < DIM; b++) begin
                ones = int'(pick[0][b]) + int'(pick[1][b]) + int'(pick[2][b]);
                m_out[b] = (ones >= 2);
            end
            m_emit = 1'b1;
            for (int k = 0; k < 3; k++) m_held[k] = 1'b0;
        end else if (any_held) begin
            m_waited++;
            if (m_waited == int'(TIMEOUT)) begin
                for (int k = 0; k < 3; k++) m_held[k] = 1'b0;
                m_drops++;
                m_to = 1'b1;
            end else begin
                for (int k = 0; k < 3; k++) if (got[k]) begin m_held[k] = 1'b1; m_val[k] = hin[k]; end
            end
        end else if (any_got) begin
            m_waited = 0;
            for (int k = 0; k < 3; k++) if (got[k]) begin m_held[k] = 1'b1; m_val[k] = hin[k]; end
        end
    endtask

    task automatic check_model();
        logic [2:0] er;
        for (int k = 0; k < 3; k++) er[k] = !m_emit && !m_held[k];
        chk("valid",      32'(hvout_valid), 32'(m_emit));
        chk("hvout",      32'(hvout), 32'(m_out));
        chk("ready",      32'({hvin3_ready, hvin2_ready, hvin1_ready}), 32'(er));
        chk("timeout",    32'(timeout), 32'(m_to));
        chk("drops",      32'(drop_count), (m_drops > 65535) ? 32'd65535 : 32'(m_drops));
        chk("sat_valid",  32'(s_valid), 32'(m_emit));
        chk("sat_hvout",  32'(s_out), 32'(m_out));
        chk("sat_ready",  32'({s_rdy3, s_rdy2, s_rdy1}), 32'(er));
        chk("sat_timeout", 32'(s_to), 32'(m_to));
        chk("sat_drops",  32'(s_drops), (m_drops > 3) ? 32'd3 : 32'(m_drops));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic [2:0] v, input logic [DIM-1:0] a, input logic [DIM-1:0] b,
                         input logic [DIM-1:0] c, input logic r);
        vin = v; hin[0] = a; hin[1] = b; hin[2] = c; hvout_ready = r;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(hvout_valid), 32'd0);
        chk({tag, "_hvout"}, 32'(hvout), 32'd0);
        chk({tag, "_ready"}, 32'({hvin3_ready, hvin2_ready, hvin1_ready}), 32'd7);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_drops"}, 32'(drop_count), 32'd0);
    endtask

    initial begin
        int pct;
        tbl[0]  = '{3'b111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 3'b000};
        tbl[1]  = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b111};
        tbl[2]  = '{3'b010, 16'h0000, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b101};
        tbl[3]  = '{3'b010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b101};
        tbl[4]  = '{3'b010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b101};
        tbl[5]  = '{3'b011, 16'h5555, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b100};
        tbl[6]  = '{3'b010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b100};
        tbl[7]  = '{3'b010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b100};
        tbl[8]  = '{3'b010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b100};
        tbl[9]  = '{3'b110, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 3'b000};
        tbl[10] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b111};

        rst = 1'b1;
        drive(3'b000, '0, '0, '0, 1'b0);
        step();
        chk_reset_values("reset");
        step();
        rst = 1'b0;

        // Directed table: all-three-at-once, then staggered arrival with a repeat valid on slot 2.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].h1, tbl[i].h2, tbl[i].h3, tbl[i].rdy);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(hvout_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_hvout", i), 32'(hvout), 32'(tbl[i].e_out));
            chk($sformatf("tbl%0d_ready", i), 32'({hvin3_ready, hvin2_ready, hvin1_ready}),
                32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'd0);
        end

        // Back-pressure in EMIT with new valids pending.
        drive(3'b111, 16'h1234, 16'h1234, 16'hFFFF, 1'b0);
        step();
        chk("bp_first_valid", 32'(hvout_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(3'b111, 16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b0);
            step();
            chk("bp_hold_valid", 32'(hvout_valid), 32'd1);
            chk("bp_hold_hvout", 32'(hvout), 32'h1234);
            chk("bp_hold_ready", 32'({hvin3_ready, hvin2_ready, hvin1_ready}), 32'd0);
        end
        hvout_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(hvout_valid), 32'd0);
        chk("bp_release_ready", 32'({hvin3_ready, hvin2_ready, hvin1_ready}), 32'd7);
        step();
        chk("bp_next_set", 32'(hvout), 32'h0F0F);
        drive(3'b000, '0, '0, '0, 1'b1);
        step();

        // Timeout: lone hvin1 is dropped after exactly TIMEOUT collecting cycles.
        drive(3'b001, 16'hBEEF, '0, '0, 1'b1);
        step();
        drive(3'b000, '0, '0, '0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("to_pulse_c%0d", i + 1), 32'(timeout), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("to_drops", 32'(drop_count), 32'd1);
        chk("to_ready1", 32'(hvin1_ready), 32'd1);
        drive(3'b110, '0, 16'hF00F, 16'h0FF0, 1'b1);
        step();
        chk("to_fresh_ready", 32'({hvin3_ready, hvin2_ready, hvin1_ready}), 32'd1);
        drive(3'b001, 16'hFF00, '0, '0, 1'b1);
        step();
        chk("to_fresh_hvout", 32'(hvout), 32'hFF00);
        drive(3'b000, '0, '0, '0, 1'b1);
        step();

        // Completion in the last collecting cycle wins over the drop.
        drive(3'b001, 16'hFF00, '0, '0, 1'b1);
        step();
        drive(3'b000, '0, '0, '0, 1'b1);
        for (int i = 1; i <= 7; i++) step();
        drive(3'b110, '0, 16'hF0F0, 16'h0000, 1'b1);
        step();
        chk("last_valid", 32'(hvout_valid), 32'd1);
        chk("last_hvout", 32'(hvout), 32'hF000);
        chk("last_timeout", 32'(timeout), 32'd0);
        chk("last_drops", 32'(drop_count), 32'd1);
        drive(3'b000, '0, '0, '0, 1'b1);
        step();

        // Five more drops: narrow counter pins at all-ones.
        for (int n = 0; n < 5; n++) begin
            drive(3'b100, '0, '0, 16'h1111, 1'b1);
            step();
            drive(3'b000, '0, '0, '0, 1'b1);
            for (int i = 0; i < 8; i++) step();
        end
        chk("sat_count", 32'(s_drops), 32'd3);
        chk("wide_count", 32'(drop_count), 32'd6);

        // Reset mid-COLLECT and mid-EMIT.
        drive(3'b001, 16'h7777, '0, '0, 1'b1);
        step();
        rst = 1'b1;
        drive(3'b000, '0, '0, '0, 1'b1);
        step();
        chk_reset_values("rst_collect");
        rst = 1'b0;
        drive(3'b111, 16'h1234, 16'h1234, 16'h0000, 1'b0);
        step();
        chk("rst_emit_pre", 32'(hvout_valid), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_values("rst_emit");
        rst = 1'b0;

        // Random traffic: dense arrivals first, then sparse ones that provoke timeouts.
        for (int n = 0; n < 3000; n++) begin
            pct = (n < 1500) ? 40 : 8;
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 3; k++) begin
                vin[k] = ($urandom_range(0, 99) < pct);
                hin[k] = DIM'($urandom);
            end
            hvout_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
